// File: rtl/vend_pkg.sv
// Shared widths, FSM state encoding and price lookup for the vending controller.
package vend_pkg;

    localparam int unsigned NumSlots  = 4;
    localparam int unsigned SlotW     = 2;
    localparam int unsigned CreditW   = 8;
    localparam int unsigned QtyW      = 4;
    localparam int unsigned MoneyW    = 11;
    localparam int unsigned PriceW    = 4;
    localparam int unsigned PriceTabW = NumSlots * PriceW;

    // FSM state encoding
    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StCollect  = 3'd1;
    localparam logic [2:0] StCheck    = 3'd2;
    localparam logic [2:0] StReject   = 3'd3;
    localparam logic [2:0] StDispense = 3'd4;
    localparam logic [2:0] StChange   = 3'd5;

    // Price of one unit in a slot; slot i occupies bits [4i+3:4i] of the table.
    function automatic logic [PriceW-1:0] price_lookup(input logic [PriceTabW-1:0] tbl,
                                                       input logic [SlotW-1:0]     slot);
        return tbl[int'(slot) * PriceW +: PriceW];
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-slot stock registers with one read port, a saturating-add port (restock)
// and a decrement port (sale). The controller never enables both in one cycle.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = NumSlots,
    parameter int unsigned QTY_W      = QtyW,
    parameter int unsigned INIT_STOCK = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(NUM_SLOTS)-1:0] rd_slot_i,
    output logic [QTY_W-1:0]             rd_qty_o,
    input  logic                         add_en_i,
    input  logic [$clog2(NUM_SLOTS)-1:0] add_slot_i,
    input  logic [QTY_W-1:0]             add_qty_i,
    input  logic                         dec_en_i,
    input  logic [$clog2(NUM_SLOTS)-1:0] dec_slot_i,
    input  logic [QTY_W-1:0]             dec_qty_i
);

    localparam int unsigned SelW = $clog2(NUM_SLOTS);

    logic [QTY_W-1:0] stock_q [NUM_SLOTS];
    logic [QTY_W-1:0] stock_d [NUM_SLOTS];
    logic [QTY_W:0]   add_sum;
    logic [QTY_W-1:0] add_sat;

    assign rd_qty_o = stock_q[rd_slot_i];
    assign add_sum  = {1'b0, stock_q[add_slot_i]} + {1'b0, add_qty_i};
    assign add_sat  = add_sum[QTY_W] ? '1 : add_sum[QTY_W-1:0];

    // Next-state stock: saturating restock or decrement on a sale.
    always_comb begin
        stock_d = stock_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (add_en_i && (add_slot_i == SelW'(i))) begin
                stock_d[i] = add_sat;
            end
            if (dec_en_i && (dec_slot_i == SelW'(i))) begin
                stock_d[i] = stock_q[i] - dec_qty_i;
            end
        end
    end

    // Stock registers, refilled to the initial level on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stock_q[i] <= QTY_W'(INIT_STOCK);
            end
        end else begin
            stock_q <= stock_d;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin collection, selection check against credit
// and stock, dispense handshake and change return. Owns the till and stock bank.
// Optional build macro VEND_TIMEOUT_EN enables the idle auto-refund in COLLECT.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned          NUM_SLOTS   = NumSlots,
    parameter int unsigned          CREDIT_W    = CreditW,
    parameter int unsigned          QTY_W       = QtyW,
    parameter int unsigned          MONEY_W     = MoneyW,
    parameter logic [PriceTabW-1:0] PRICE_TABLE = 16'h7253,
    parameter int unsigned          INIT_STOCK  = 10,
    parameter int unsigned          TIMEOUT_CYC = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         coin_valid,
    input  logic [3:0]                   coin_value,
    input  logic                         sel_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0] sel_slot,
    input  logic [QTY_W-1:0]             sel_qty,
    input  logic                         cancel,
    input  logic                         restock_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0] restock_slot,
    input  logic [QTY_W-1:0]             restock_qty,
    output logic                         dispense_valid,
    output logic [$clog2(NUM_SLOTS)-1:0] dispense_slot,
    output logic [QTY_W-1:0]             dispense_qty,
    input  logic                         dispense_ack,
    output logic                         change_valid,
    output logic [CREDIT_W-1:0]          change_amount,
    output logic                         redlight,
    output logic [CREDIT_W-1:0]          credit,
    output logic [MONEY_W-1:0]           machine_money,
    output logic                         busy
);

    localparam int unsigned SelW     = $clog2(NUM_SLOTS);
    localparam int unsigned CostW    = CREDIT_W + QTY_W;
    localparam int unsigned TillSumW = ((MONEY_W > CostW) ? MONEY_W : CostW) + 1;
    localparam logic [TillSumW-1:0] TillMax = TillSumW'((2 ** MONEY_W) - 1);

    logic [2:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [MONEY_W-1:0]  till_q, till_d;
    logic [SelW-1:0]     slot_q, slot_d;
    logic [QTY_W-1:0]    qty_q, qty_d;
    logic                redlight_q, redlight_d;

    logic [CREDIT_W:0]   coin_sum;
    logic [CostW-1:0]    cost;
    logic [TillSumW-1:0] till_sum;
    logic [QTY_W-1:0]    stock_rd;
    logic                check_ok;
    logic                stock_add_en;
    logic                stock_dec_en;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYC;
`endif

    assign coin_sum = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value);
    assign cost     = CostW'(price_lookup(PRICE_TABLE, slot_q)) * CostW'(qty_q);
    assign check_ok = (qty_q != '0) && (cost <= CostW'(credit_q)) && (stock_rd >= qty_q);
    assign till_sum = TillSumW'(till_q) + TillSumW'(cost);

    assign stock_add_en = (state_q == StIdle) && restock_valid;
    assign stock_dec_en = (state_q == StCheck) && check_ok;

    vend_stock_bank #(
        .NUM_SLOTS  (NUM_SLOTS),
        .QTY_W      (QTY_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_slot_i  (slot_q),
        .rd_qty_o   (stock_rd),
        .add_en_i   (stock_add_en),
        .add_slot_i (restock_slot),
        .add_qty_i  (restock_qty),
        .dec_en_i   (stock_dec_en),
        .dec_slot_i (slot_q),
        .dec_qty_i  (qty_q)
    );

    // Transaction FSM and credit/till bookkeeping.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        till_d     = till_q;
        slot_d     = slot_q;
        qty_d      = qty_q;
        redlight_d = 1'b0;
`ifdef VEND_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            StIdle: begin
                if (coin_valid) begin
                    credit_d = CREDIT_W'(coin_value);
                    state_d  = StCollect;
`ifdef VEND_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                end
            end
            StCollect: begin
                // Coin is applied before any selection in the same cycle.
                if (coin_valid) begin
                    if (coin_sum[CREDIT_W]) begin
                        redlight_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end
                end
                if (cancel) begin
                    state_d = StChange;
                end else if (sel_valid) begin
                    slot_d  = sel_slot;
                    qty_d   = sel_qty;
                    state_d = StCheck;
                end
`ifdef VEND_TIMEOUT_EN
                if (coin_valid || sel_valid) begin
                    tmo_d = '0;
                end else if (!cancel) begin
                    if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                        state_d = StChange;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
`endif
            end
            StCheck: begin
                if (check_ok) begin
                    credit_d = credit_q - cost[CREDIT_W-1:0];
                    till_d   = (till_sum > TillMax) ? '1 : till_sum[MONEY_W-1:0];
                    state_d  = StDispense;
                end else begin
                    redlight_d = 1'b1;
                    state_d    = StReject;
                end
            end
            StReject: begin
                state_d = StCollect;
`ifdef VEND_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            StDispense: begin
                if (dispense_ack) begin
                    state_d = StChange;
                end
            end
            StChange: begin
                credit_d = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset discards credit without a change pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            credit_q   <= '0;
            till_q     <= '0;
            slot_q     <= '0;
            qty_q      <= '0;
            redlight_q <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            till_q     <= till_d;
            slot_q     <= slot_d;
            qty_q      <= qty_d;
            redlight_q <= redlight_d;
`ifdef VEND_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign dispense_valid = (state_q == StDispense);
    assign dispense_slot  = slot_q;
    assign dispense_qty   = qty_q;
    assign change_valid   = (state_q == StChange) && (credit_q != '0);
    assign change_amount  = change_valid ? credit_q : '0;
    assign redlight       = redlight_q;
    assign credit         = credit_q;
    assign machine_money  = till_q;
    assign busy           = (state_q != StIdle);

endmodule
